// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, kernel type and pixel saturation for the 3x3 convolution engine
// Ports: none (package).
package conv_pkg;

   localparam int DEF_PIX_W  = 8;
   localparam int DEF_COEF_W = 16;
   localparam int DEF_ACC_W  = 32;
   localparam int DEF_IMG_W  = 640;
   localparam int DEF_SHIFT  = 3;
   localparam int NUM_TAPS   = 9;

   typedef logic signed [DEF_COEF_W-1:0] kernel_t [NUM_TAPS];

   localparam logic signed [DEF_ACC_W-1:0] PIX_MAX = DEF_ACC_W'((1 << DEF_PIX_W) - 1);

   // Clamp a normalized signed sum into the unsigned pixel range.
   function automatic logic [DEF_PIX_W-1:0] sat_pix(input logic signed [DEF_ACC_W-1:0] v);
      if (v[DEF_ACC_W-1])
         return '0;
      else if (v > PIX_MAX)
         return '1;
      else
         return v[DEF_PIX_W-1:0];
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - one-line delay RAM, read-before-write, advanced on enable
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset (pointer only, RAM contents kept)
//   en    - advance: write din at the pointer and step the pointer
//   din   - pixel entering the line delay
//   dout  - pixel written DEPTH enables ago at the current pointer
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W,
   parameter int DEPTH = DEF_IMG_W
)
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PIX_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;

   // Asynchronous read of the slot about to be overwritten gives the
   // read-before-write behaviour of a single-port shift RAM.
   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (en)
         mem[ptr] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ptr <= '0;
      else if (en) begin
         if (ptr == PTR_W'(DEPTH - 1))
            ptr <= '0;
         else
            ptr <= ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/conv_top.sv
// rtl/conv_top.sv - streaming 3x3 convolution with programmable kernel, shift and clamp
// Ports:
//   clk          - clock, rising edge
//   rstn         - asynchronous active-low reset
//   valid_in     - px_in valid this cycle
//   px_in        - input pixel, raster order
//   kernel_wr    - coefficient write strobe
//   kernel_addr  - coefficient index 0..8 (row*3+col), 9..15 ignored
//   kernel_data  - signed coefficient
//   valid_out    - px_out valid this cycle
//   px_out       - convolved, normalized, clamped pixel (holds when not valid)
module conv_top
   import conv_pkg::*;
#(
   parameter int PIX_W  = DEF_PIX_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int SHIFT  = DEF_SHIFT
)
(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     valid_in,
   input  logic [PIX_W-1:0]         px_in,
   input  logic                     kernel_wr,
   input  logic [3:0]               kernel_addr,
   input  logic signed [COEF_W-1:0] kernel_data,
   output logic                     valid_out,
   output logic [PIX_W-1:0]         px_out
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   logic [COL_W-1:0]              col;
   logic [1:0]                    row;
   logic [PIX_W-1:0]              lb0_out;
   logic [PIX_W-1:0]              lb1_out;
   logic [PIX_W-1:0]              win [3][3];
   kernel_t                       coef;
   logic                          win_valid;
   logic                          sum_valid;
   logic signed [PIX_W+COEF_W:0]  prod [NUM_TAPS];
   logic signed [ACC_W-1:0]       sum_c;
   logic signed [ACC_W-1:0]       sum_q;
   logic signed [ACC_W-1:0]       sum_sh;

   // lb0 delays the input by one line (y-1), lb1 by two lines (y-2).
   conv_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
      .clk  (clk),
      .rstn (rstn),
      .en   (valid_in),
      .din  (px_in),
      .dout (lb0_out)
   );

   conv_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
      .clk  (clk),
      .rstn (rstn),
      .en   (valid_in),
      .din  (lb0_out),
      .dout (lb1_out)
   );

   // Row saturates at 2: from then on every line is eligible for output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col <= '0;
         row <= '0;
      end else if (valid_in) begin
         if (col == COL_W'(IMG_W - 1)) begin
            col <= '0;
            if (row != 2'd2)
               row <= row + 2'd1;
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Window is pure datapath; stale contents are never qualified.
   always_ff @(posedge clk) begin
      if (valid_in) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb1_out;
         win[1][2] <= lb0_out;
         win[2][2] <= px_in;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         win_valid <= 1'b0;
      else
         win_valid <= valid_in && (row == 2'd2) && (col >= COL_W'(2));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_TAPS; i++)
            coef[i] <= '0;
      end else if (kernel_wr && (kernel_addr <= 4'd8)) begin
         coef[kernel_addr] <= kernel_data;
      end
   end

   // Pixels are zero-extended so 255 stays positive in the signed product.
   always_comb begin
      sum_c = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            prod[r*3+c] = $signed({1'b0, win[r][c]}) * coef[r*3+c];
            sum_c       = sum_c + ACC_W'(prod[r*3+c]);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sum_q     <= '0;
         sum_valid <= 1'b0;
      end else begin
         sum_q     <= sum_c;
         sum_valid <= win_valid;
      end
   end

   assign sum_sh = sum_q >>> SHIFT;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_out <= 1'b0;
         px_out    <= '0;
      end else begin
         valid_out <= sum_valid;
         if (sum_valid)
            px_out <= sat_pix(sum_sh);
      end
   end

endmodule

// File: tb/tb_conv_top.sv
// tb/tb_conv_top.sv - directed self-checking bench for conv_top (IMG_W=8)
module tb_conv_top;

   logic               clk;
   logic               rstn;
   logic               valid_in;
   logic [7:0]         px_in;
   logic               kernel_wr;
   logic [3:0]         kernel_addr;
   logic signed [15:0] kernel_data;
   logic               valid_out;
   logic [7:0]         px_out;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;
   int out_v[$];
   int out_t[$];
   int exp_v[$];
   int exp_t[$];

   conv_top #(.PIX_W(8), .COEF_W(16), .ACC_W(32), .IMG_W(8), .SHIFT(3)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .valid_in    (valid_in),
      .px_in       (px_in),
      .kernel_wr   (kernel_wr),
      .kernel_addr (kernel_addr),
      .kernel_data (kernel_data),
      .valid_out   (valid_out),
      .px_out      (px_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt++;

   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         out_v.push_back(int'(px_out));
         out_t.push_back(edge_cnt);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic clear_q();
      out_v.delete();
      out_t.delete();
      exp_v.delete();
      exp_t.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn      = 1'b0;
      valid_in  = 1'b0;
      kernel_wr = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      clear_q();
   endtask

   task automatic wr_coef(input int a, input int d);
      @(negedge clk);
      kernel_wr   = 1'b1;
      kernel_addr = 4'(a);
      kernel_data = 16'(d);
      @(negedge clk);
      kernel_wr = 1'b0;
   endtask

   // mode 0: ramp y*16+x, mode 1: constant cval
   task automatic send_frame(input int lines, input int mode, input int cval, input bit gaps);
      for (int y = 0; y < lines; y++) begin
         for (int x = 0; x < 8; x++) begin
            @(negedge clk);
            valid_in = 1'b1;
            px_in    = (mode == 0) ? 8'(y*16 + x) : 8'(cval);
            if (y >= 2 && x >= 2)
               exp_t.push_back(edge_cnt + 3);
            if (gaps) begin
               @(negedge clk);
               valid_in = 1'b0;
            end
         end
      end
      @(negedge clk);
      valid_in = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic exp_ident(input int lines);
      for (int r = 2; r < lines; r++)
         for (int k = 0; k < 6; k++)
            exp_v.push_back((r-1)*16 + k + 1);
   endtask

   task automatic exp_const(input int n, input int v);
      for (int i = 0; i < n; i++)
         exp_v.push_back(v);
   endtask

   task automatic cmp_out(input string tag);
      chk({tag, "_count"}, 32'(out_v.size()), 32'(exp_v.size()));
      chk({tag, "_pulses"}, 32'(out_t.size()), 32'(exp_t.size()));
      for (int i = 0; i < exp_v.size(); i++) begin
         if (i < out_v.size())
            chk($sformatf("%s_val%0d", tag, i), 32'(out_v[i]), 32'(exp_v[i]));
         if (i < out_t.size() && i < exp_t.size())
            chk($sformatf("%s_edge%0d", tag, i), 32'(out_t[i]), 32'(exp_t[i]));
      end
      clear_q();
   endtask

   task automatic load_ident();
      wr_coef(4, 8);
   endtask

   initial begin
      rstn        = 1'b1;
      valid_in    = 1'b0;
      px_in       = '0;
      kernel_wr   = 1'b0;
      kernel_addr = '0;
      kernel_data = '0;
      #2 rstn = 1'b0;

      // Reset held with valid_in toggling
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         valid_in = ~valid_in;
         px_in    = 8'(i * 37);
         chk($sformatf("rst_valid%0d", i), 32'(valid_out), 32'd0);
         chk($sformatf("rst_px%0d", i), 32'(px_out), 32'd0);
      end
      valid_in = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      clear_q();

      // Identity kernel, 6-line ramp
      load_ident();
      send_frame(6, 0, 0, 1'b0);
      exp_ident(6);
      cmp_out("ident");
      chk("hold_px", 32'(px_out), 32'd70);
      chk("hold_valid", 32'(valid_out), 32'd0);

      // Count/latency: 4 lines continuous
      do_reset();
      load_ident();
      send_frame(4, 0, 0, 1'b0);
      exp_ident(4);
      cmp_out("count4");

      // Gaps every other cycle give identical output
      do_reset();
      load_ident();
      send_frame(6, 0, 0, 1'b1);
      exp_ident(6);
      cmp_out("gaps");

      // Blur, constant 16 -> 18
      do_reset();
      for (int i = 0; i < 9; i++) wr_coef(i, 1);
      send_frame(3, 1, 16, 1'b0);
      exp_const(6, 18);
      cmp_out("blur16");

      // Blur, constant 255 -> clamped 255
      do_reset();
      for (int i = 0; i < 9; i++) wr_coef(i, 1);
      send_frame(3, 1, 255, 1'b0);
      exp_const(6, 255);
      cmp_out("blur255");

      // Negative clamp; out-of-range address ignored
      do_reset();
      wr_coef(4, -1);
      wr_coef(12, 5);
      send_frame(3, 1, 100, 1'b0);
      exp_const(6, 0);
      cmp_out("negclamp");

      // Mid-frame reset restarts at row 0, col 0
      do_reset();
      load_ident();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         valid_in = 1'b1;
         px_in    = 8'(200 + i);
      end
      #2 rstn = 1'b0;
      valid_in = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(valid_out), 32'd0);
      chk("midrst_px", 32'(px_out), 32'd0);
      rstn = 1'b1;
      clear_q();
      load_ident();
      send_frame(3, 0, 0, 1'b0);
      exp_ident(3);
      cmp_out("midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_top.md
Name: conv_top

Overview:
Streaming 3x3 2-D convolution engine for 8-bit grayscale video. It accepts one raster-order pixel per valid cycle and buffers the two previous lines internally. It applies a runtime-programmable signed 3x3 kernel, normalizes the result by a right shift and saturates it to the pixel range. It sits between the pixel DMA/stream source and the output writer in the SoC image path.

Parameters:
PIX_W, 8, pixel width (unsigned)
COEF_W, 16, kernel coefficient width (signed)
ACC_W, 32, accumulator width (signed)
IMG_W, 640, pixels per line (line-buffer depth)
SHIFT, 3, arithmetic right shift applied to the accumulated sum

Ports:
clk  in  1  single clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
valid_in  in  1  px_in valid this cycle
px_in  in  PIX_W  input pixel, raster order
kernel_wr  in  1  kernel coefficient write strobe
kernel_addr  in  4  coefficient index, 0..8 = row*3+col
kernel_data  in  COEF_W  signed coefficient
valid_out  out  1  px_out valid this cycle
px_out  out  PIX_W  convolved, normalized, clamped pixel

Behaviour:
- Reset (async, rstn=0):
  - valid_out=0, px_out=0.
  - Column/row counters, valid pipeline and all 9 coefficients are cleared to 0.
  - Line-buffer RAM contents are not reset.
  - Reset mid-frame restarts at row 0, col 0.
- Kernel writes:
  - On a clock edge with kernel_wr=1 and kernel_addr<=8, coef[kernel_addr] <= kernel_data.
  - Addresses 9..15 are ignored.
  - Writes are allowed at any time; a new value is used by every accumulation stage evaluated after the write edge.
- Input side:
  - Line buffers, window and counters advance only on edges with valid_in=1; gaps in valid_in are allowed.
  - col counts 0..IMG_W-1 and wraps to 0.
  - On wrap, row increments and saturates at 2. There is no frame height; frame restart is by reset.
- Window:
  - 3x3 window w[r][c]: r=0 is the oldest line (y-2), c=0 the oldest column (x-2), w[2][2] is the current pixel.
  - Operation is correlation, not flipped: sum = SUM over r,c of coef[r*3+c]*w[r][c].
- Output validity:
  - A pixel accepted at (row,col) produces an output only if row>=2 and col>=2. The output corresponds to centre (row-1, col-1).
  - No border padding.
  - Each line after the first two yields IMG_W-2 outputs.
- Pipeline (fixed latency, no backpressure):
  - Edge E: pixel accepted, window updated.
  - E+1: products and sum registered.
  - E+2: px_out/valid_out registered.
  - valid_out is high for exactly one cycle per qualifying accepted pixel, in the cycle after E+2.
  - When no output is valid, valid_out=0 and px_out holds its last value.
- Arithmetic:
  - Each pixel is zero-extended to PIX_W+1 signed bits and multiplied by a signed COEF_W coefficient.
  - The nine products are summed in signed ACC_W; overflow wraps (not expected with defaults).
  - The sum is arithmetic-shifted right by SHIFT, then clamped: <0 -> 0, >2^PIX_W-1 -> 2^PIX_W-1.

Decomposition:
- conv_pkg:
  - default widths
  - NUM_TAPS=9
  - kernel array typedef (9 x signed COEF_W)
  - clamp/saturate function
- One sub-module, conv_line_buffer: IMG_W-deep PIX_W single-port read-before-write shift RAM, advanced on enable. Instantiated twice.
- Window, MAC and clamp logic live in conv_top.

Test Plan:
- Reset: hold rstn=0 with valid_in toggling -> valid_out=0, px_out=0 throughout; after release, no output until row 2 col 2.
- Identity, IMG_W=8, SHIFT=3, coef[4]=8 (others 0), px=y*16+x -> for 6 lines, 24 outputs; output k of row r (r>=2) equals (r-1)*16+(k+1).
- Blur: all coefs 1, constant image 16 -> every output 144>>3 = 18; with constant 255 -> 2295>>3 = 286, clamped to 255.
- Negative clamp: coef[4]=-1 (others 0), image 100 -> every output 0. Write to kernel_addr=12 with data 5 -> no effect.
- Count/latency: IMG_W=8, 4 lines continuous -> exactly 12 valid_out pulses; each pulse appears in the cycle after the 3rd edge following the qualifying pixel; none during rows 0-1 or cols 0-1.
- Gaps: same image streamed with valid_in=0 inserted every other cycle -> identical output sequence to the continuous stream.
